// File: rtl/imagem_pkg.sv
// Shared types and constants for the image RAM arbiter slice.
package imagem_pkg;

    localparam int IMG_ADDR_W = 18;
    localparam int IMG_DATA_W = 32;
    localparam int IMG_BE_W   = 4;
    localparam int IMG_RD_LAT = 1;

    typedef logic master_id_t;

    localparam master_id_t MASTER0 = 1'b0;
    localparam master_id_t MASTER1 = 1'b1;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read tag delay line: carries {valid, id} of each accepted read alongside
// the RAM read latency so returning data can be steered to its owner.
module rd_tag_pipe
    import imagem_pkg::*;
#(
    parameter int DEPTH = IMG_RD_LAT
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [DEPTH];

    // Shift tags one stage per clock; reset drops every read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/imagem_ram_arbiter.sv
// Round-robin arbiter sharing one single-port image RAM between the Nios
// data master (m0) and the image accelerator (m1). One command per clock;
// read data is routed back using a tag pipeline matched to RAM latency.
module imagem_ram_arbiter
    import imagem_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W,
    parameter int DATA_W = IMG_DATA_W,
    parameter int BE_W   = IMG_BE_W,
    parameter int RD_LAT = IMG_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic       req0;
    logic       req1;
    logic       grant_valid;
    master_id_t grant_id;
    master_id_t last_grant;
    logic       sel_read;
    logic       sel_write;
    rd_tag_t    tag_in;
    rd_tag_t    tag_out;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant decision: sole requester wins; on a tie the master not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = MASTER0;
        if (!reset) begin
            if (req0 && req1) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (req0) begin
                grant_valid = 1'b1;
                grant_id    = MASTER0;
            end else if (req1) begin
                grant_valid = 1'b1;
                grant_id    = MASTER1;
            end
        end
    end

    // Remember who was served last; idle cycles leave the history untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= MASTER1;
        end else if (grant_valid) begin
            last_grant <= grant_id;
        end
    end

    // Steer the granted master's command onto the RAM port (m0 when idle).
    always_comb begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
        sel_read       = m0_read;
        sel_write      = m0_write;
        if (grant_valid && grant_id == MASTER1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            sel_read       = m1_read;
            sel_write      = m1_write;
        end
        ram_chipselect = grant_valid;
        ram_write      = grant_valid & sel_write;
    end

    assign m0_waitrequest = ~(grant_valid && grant_id == MASTER0);
    assign m1_waitrequest = ~(grant_valid && grant_id == MASTER1);
    assign ram_clken      = ~reset;

    // Read+write together is a write, so only pure reads are tagged.
    assign tag_in.valid = grant_valid & sel_read & ~sel_write;
    assign tag_in.id    = grant_id;

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Qualifying with reset suppresses a tag that was already at the output
    // stage when reset arrived.
    assign m0_readdatavalid = ~reset & tag_out.valid & (tag_out.id == MASTER0);
    assign m1_readdatavalid = ~reset & tag_out.valid & (tag_out.id == MASTER1);
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

endmodule
